// File: rtl/multi_wave_gen.sv
// -----------------------------------------------------------------------------
// multi_wave_gen
//   Registered waveform generator producing a triangle, sawtooth or square
//   wave between 0 and a run-time limit 'top', with single-cycle event pulses.
//
// Ports
//   clk         rising-edge clock, sole clock domain
//   res         asynchronous active-high reset
//   en          run enable; low freezes all state and suppresses pulses
//   mode        00 triangle, 01 sawtooth, 10 square, 11 hold (pause)
//   step        unsigned ramp increment per active cycle
//   top         unsigned upper limit of the output swing
//   d_out       registered waveform sample
//   peak        one-cycle pulse on the cycle d_out becomes top
//   period_end  one-cycle pulse on the cycle d_out returns to 0 ending a period
//   dbg_state   current FSM state (IDLE=0, UP=1, DOWN=2, HIGH=3, LOW=4)
//
// Mode 11 is a pause: it does not count as a mode change, so d_out, state,
// counter and the registered mode all hold, and returning to the previously
// running mode resumes the waveform where it stopped.
// STEP_W must not exceed WIDTH.
// -----------------------------------------------------------------------------
module multi_wave_gen #(
    parameter int WIDTH   = 9,
    parameter int STEP_W  = 4,
    parameter int SQ_HALF = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  top,
    output logic [WIDTH-1:0]  d_out,
    output logic              peak,
    output logic              period_end,
    output logic [2:0]        dbg_state
);

    localparam int CW = $clog2(SQ_HALF + 1);

    localparam logic [1:0] M_TRI  = 2'b00;
    localparam logic [1:0] M_SAW  = 2'b01;
    localparam logic [1:0] M_SQ   = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_HIGH = 3'd3,
        S_LOW  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             peak_q, peak_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    // One extra bit on the ramp arithmetic so d_out + step never wraps.
    logic [WIDTH:0]   cur_ext, top_ext, step_ext, sum;
    logic [WIDTH-1:0] diff;

    assign cur_ext  = {1'b0, d_out_q};
    assign top_ext  = {1'b0, top};
    assign step_ext = (WIDTH + 1)'(step);
    assign sum      = cur_ext + step_ext;
    // Only used when d_out > step, so it cannot underflow.
    assign diff     = d_out_q - step_ext[WIDTH-1:0];

    logic active, restart;
    logic top_zero, over_top, step_zero, sum_ge_top, at_top, le_step;
    logic sq_first, sq_last;

    assign active     = en && (mode != M_HOLD);
    // Leaving IDLE and switching modes both land in the new mode's start state.
    assign restart    = active && ((state_q == S_IDLE) || (mode != mode_q));
    assign top_zero   = (top == '0);
    assign over_top   = (d_out_q > top);
    assign step_zero  = (step == '0);
    assign sum_ge_top = (sum >= top_ext);
    assign at_top     = (d_out_q == top);
    assign le_step    = (cur_ext <= step_ext);
    assign sq_first   = (cnt_q == '0);
    assign sq_last    = (cnt_q == CW'(SQ_HALF - 1));

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            d_out_q <= '0;
            peak_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= M_TRI;
        end else begin
            state_q <= state_d;
            d_out_q <= d_out_d;
            peak_q  <= peak_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: FSM state, square half-period counter, registered mode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (restart) begin
            mode_d  = mode;
            cnt_d   = '0;
            state_d = (mode == M_SQ) ? S_HIGH : S_UP;
        end else if (active) begin
            case (state_q)
                S_UP: begin
                    // Only the triangle turns around; the sawtooth stays in UP.
                    if ((mode_q == M_TRI) && !top_zero &&
                        (over_top || (!step_zero && sum_ge_top))) begin
                        state_d = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (top_zero) begin
                        state_d = S_UP;
                    end else if (!over_top && !step_zero && le_step) begin
                        state_d = S_UP;
                    end
                end
                S_HIGH: begin
                    if (sq_last) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_LOW: begin
                    if (sq_last) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: next sample and event pulses
    always_comb begin
        d_out_d = d_out_q;
        peak_d  = 1'b0;
        pend_d  = 1'b0;
        if (restart) begin
            d_out_d = '0;
        end else if (active) begin
            case (state_q)
                S_UP, S_DOWN: begin
                    if (top_zero) begin
                        d_out_d = '0;
                    end else if (over_top) begin
                        // top was lowered beneath the current sample
                        d_out_d = top;
                        peak_d  = 1'b1;
                    end else if (!step_zero) begin
                        if (state_q == S_DOWN) begin
                            if (le_step) begin
                                d_out_d = '0;
                                pend_d  = 1'b1;
                            end else begin
                                d_out_d = diff;
                            end
                        end else if ((mode_q == M_SAW) && at_top) begin
                            d_out_d = '0;
                            pend_d  = 1'b1;
                        end else if (sum_ge_top) begin
                            d_out_d = top;
                            peak_d  = 1'b1;
                        end else begin
                            d_out_d = sum[WIDTH-1:0];
                        end
                    end
                end
                S_HIGH: begin
                    d_out_d = top;
                    peak_d  = sq_first && !top_zero;
                end
                S_LOW: begin
                    d_out_d = '0;
                    pend_d  = sq_first && (d_out_q != '0);
                end
                default: begin
                    d_out_d = d_out_q;
                end
            endcase
        end
    end

    assign d_out      = d_out_q;
    assign peak       = peak_q;
    assign period_end = pend_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_wave_gen
//   Directed stimulus for multi_wave_gen with hand-computed expected sequences,
//   plus an integer-arithmetic reference model compared on every cycle.
// -----------------------------------------------------------------------------
module tb_multi_wave_gen;

    localparam int WIDTH  = 9;
    localparam int STEP_W = 4;
    localparam int SQ     = 4;

    logic              clk = 1'b0;
    logic              res;
    logic              en;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  top;
    logic [WIDTH-1:0]  d_out;
    logic              peak;
    logic              period_end;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    multi_wave_gen #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .SQ_HALF(SQ)
    ) dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .top       (top),
        .d_out     (d_out),
        .peak      (peak),
        .period_end(period_end),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    // Plain integers: the output value, the ramp direction, and for the square
    // wave the number of square cycles elapsed since the mode started.
    int m_out     = 0;
    int m_t       = 0;
    int m_mode    = 0;
    bit m_peak    = 0;
    bit m_pend    = 0;
    bit m_started = 0;
    bit m_rising  = 1;
    int mv, ms, mt, mph;

    always @(posedge clk or posedge res) begin
        if (res) begin
            m_out = 0; m_t = 0; m_mode = 0; m_peak = 0; m_pend = 0;
            m_started = 0; m_rising = 1;
        end else begin
            m_peak = 0;
            m_pend = 0;
            if (en && mode != 2'b11) begin
                if (!m_started || int'(mode) != m_mode) begin
                    m_started = 1; m_mode = int'(mode); m_out = 0; m_rising = 1; m_t = 0;
                end else if (mode == 2'b10) begin
                    mph = m_t % (2 * SQ);
                    if (mph < SQ) begin
                        if (mph == 0 && top != 0) m_peak = 1;
                        m_out = int'(top);
                    end else begin
                        if (mph == SQ && m_out != 0) m_pend = 1;
                        m_out = 0;
                    end
                    m_t = m_t + 1;
                end else begin
                    mv = m_out; ms = int'(step); mt = int'(top);
                    if (mt == 0) begin
                        m_out = 0; m_rising = 1;
                    end else if (mv > mt) begin
                        m_out = mt; m_peak = 1;
                        if (mode == 2'b00) m_rising = 0;
                    end else if (ms == 0) begin
                        m_out = mv;
                    end else if (mode == 2'b01) begin
                        if (mv == mt) begin m_out = 0; m_pend = 1; end
                        else if (mv + ms >= mt) begin m_out = mt; m_peak = 1; end
                        else m_out = mv + ms;
                    end else if (m_rising) begin
                        if (mv + ms >= mt) begin m_out = mt; m_peak = 1; m_rising = 0; end
                        else m_out = mv + ms;
                    end else begin
                        if (mv <= ms) begin m_out = 0; m_pend = 1; m_rising = 1; end
                        else m_out = mv - ms;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!res) begin
            n_cmp = n_cmp + 1;
            if (int'(d_out) != m_out || peak !== m_peak || period_end !== m_pend) begin
                n_bad = n_bad + 1;
                $display("FAIL model @%0t: got d_out=%0d peak=%0b period_end=%0b, want d_out=%0d peak=%0b period_end=%0b",
                         $time, d_out, peak, period_end, m_out, m_peak, m_pend);
            end
            n_cmp = n_cmp + 1;
            if (peak && period_end) begin
                n_bad = n_bad + 1;
                $display("FAIL pulse_overlap @%0t: got peak=1 period_end=1, want at most one", $time);
            end
        end
    end

    // ---------------- directed checks ----------------
    // exp_f: 0 no pulse, 1 peak, 2 period_end. The model is pinned too.
    task automatic chk(input string name, input int exp_d, input int exp_f);
        bit exp_pk, exp_pe;
        exp_pk = (exp_f == 1);
        exp_pe = (exp_f == 2);
        n_cmp = n_cmp + 1;
        if (int'(d_out) != exp_d || peak !== exp_pk || period_end !== exp_pe) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got d_out=%0d peak=%0b period_end=%0b, want d_out=%0d peak=%0b period_end=%0b",
                     name, d_out, peak, period_end, exp_d, exp_pk, exp_pe);
        end
        n_cmp = n_cmp + 1;
        if (m_out != exp_d || m_peak != exp_pk || m_pend != exp_pe) begin
            n_bad = n_bad + 1;
            $display("FAIL %s_model: got d_out=%0d peak=%0b period_end=%0b, want d_out=%0d peak=%0b period_end=%0b",
                     name, m_out, m_peak, m_pend, exp_d, exp_pk, exp_pe);
        end
    endtask

    int sd[$];
    int sf[$];

    task automatic run_seq(input string name);
        for (int i = 0; i < sd.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", name, i), sd[i], sf[i]);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; returns at a later negedge with reset released.
    task automatic do_reset();
        #2 res = 1'b1;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp = n_cmp + 1;
        if (got != want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    int pk_at[$];
    int pe_at[$];

    initial begin
        res = 1'b0; en = 1'b0; mode = 2'b00; step = '0; top = '0;
        #1 res = 1'b1;
        #1 chk("reset_state", 0, 0);
        @(negedge clk);
        res = 1'b0;

        // Triangle, step 5, top 12
        mode = 2'b00; step = 4'd5; top = 9'd12; en = 1'b1;
        sd = '{0, 5, 10, 12, 7, 2, 0, 5, 10};
        sf = '{0, 0, 0,  1,  0, 0, 2, 0, 0};
        run_seq("tri_5_12");

        // Sawtooth, step 4, top 10; then pause, lowered top, step 0, top 0
        do_reset();
        mode = 2'b01; step = 4'd4; top = 9'd10; en = 1'b1;
        sd = '{0, 4, 8, 10, 0, 4, 8};
        sf = '{0, 0, 0, 1,  2, 0, 0};
        run_seq("saw_4_10");
        mode = 2'b11;
        sd = '{8, 8, 8};
        sf = '{0, 0, 0};
        run_seq("hold_mode");
        mode = 2'b01;
        sd = '{10, 0, 4, 8};
        sf = '{1,  2, 0, 0};
        run_seq("saw_resume");
        top = 9'd5;
        sd = '{5, 0, 4, 5};
        sf = '{1, 2, 0, 1};
        run_seq("saw_top_lowered");
        step = 4'd0;
        sd = '{5, 5};
        sf = '{0, 0};
        run_seq("saw_step0");
        top = 9'd0;
        sd = '{0, 0, 0};
        sf = '{0, 0, 0};
        run_seq("saw_top0");

        // Square, half period 4, top 300, with an enable gap
        do_reset();
        mode = 2'b10; step = 4'd0; top = 9'd300; en = 1'b1;
        sd = '{0, 300, 300, 300, 300, 0, 0, 0, 0, 300, 300, 300, 300, 0};
        sf = '{0, 1,   0,   0,   0,   2, 0, 0, 0, 1,   0,   0,   0,   2};
        run_seq("square");
        en = 1'b0;
        sd = '{0, 0, 0};
        sf = '{0, 0, 0};
        run_seq("square_en0");
        en = 1'b1;
        sd = '{0, 0, 0, 300};
        sf = '{0, 0, 0, 1};
        run_seq("square_resume");

        // Triangle at 200 rising, top dropped to 100, then en low for 10 cycles
        do_reset();
        mode = 2'b00; step = 4'd10; top = 9'd400; en = 1'b1;
        wait_cycles(21);
        chk("tri_at_200", 200, 0);
        top = 9'd100;
        sd = '{100, 90, 80};
        sf = '{1,   0,  0};
        run_seq("tri_top_drop");
        en = 1'b0;
        sd = '{80, 80, 80, 80, 80, 80, 80, 80, 80, 80};
        sf = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0};
        run_seq("tri_en0");
        en = 1'b1;
        sd = '{70, 60};
        sf = '{0,  0};
        run_seq("tri_en1");

        // Asynchronous reset at 37, then mode switch at 50
        do_reset();
        mode = 2'b00; step = 4'd1; top = 9'd511; en = 1'b1;
        wait_cycles(38);
        chk("tri_at_37", 37, 0);
        #3 res = 1'b1;
        #1 chk("async_reset", 0, 0);
        @(negedge clk);
        res = 1'b0;
        wait_cycles(51);
        chk("tri_at_50", 50, 0);
        mode = 2'b01;
        sd = '{0, 1, 2};
        sf = '{0, 0, 0};
        run_seq("mode_switch");

        // Full-swing triangle: peaks and period ends 1022 cycles apart
        do_reset();
        mode = 2'b00; step = 4'd1; top = 9'd511; en = 1'b1;
        for (int i = 1; i <= 2050; i++) begin
            @(negedge clk);
            if (peak) pk_at.push_back(i);
            if (period_end) pe_at.push_back(i);
        end
        chk_int("full_peak_count", pk_at.size(), 2);
        chk_int("full_pend_count", pe_at.size(), 2);
        if (pk_at.size() == 2 && pe_at.size() == 2) begin
            chk_int("full_peak0", pk_at[0], 512);
            chk_int("full_peak1", pk_at[1], 1534);
            chk_int("full_pend0", pe_at[0], 1023);
            chk_int("full_pend1", pe_at[1], 2045);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad = n_bad + 1;
        $display("FAIL watchdog: got no completion by %0t, want completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
